sw_debounce_4ch: RTL and testbench
==================================

// Module: sw_debounce_4ch
// PURPOSE
//  Conditions four raw board switch/button inputs before they reach the four-input AND stage.
//  Per channel: 2-flop synchronizer, counter-based debouncer, optional one-cycle rising-edge pulse.
//  sw_db[0..3] drive the AND stage inputs A, B, C, D directly.
//  All channels are independent and share one clock domain.
// PARAMETERS
//  CNT_W            16     width of each channel's debounce counter
//  DEBOUNCE_CYCLES  50000  consecutive stable synced cycles required to accept a new level;
//                          legal range 2 .. 2**CNT_W-1, elaboration error outside it
// PORTS
//  clk        in   1  system clock; all state updates on the rising edge
//  rst        in   1  synchronous, active-high reset
//  sw_in      in   4  raw asynchronous switch levels
//  sw_db      out  4  debounced levels, registered; bit i feeds AND input A/B/C/D (i=0..3)
//  sw_rise    out  4  one-cycle pulse when sw_db[i] goes 0->1; constant 0 unless SW_EDGE_PULSE_EN
//  sw_busy    out  4  high while channel i is in COUNTING
// BEHAVIOUR
//  Reset: the interface is one clock, synchronous active-high reset named rst.
//   - rst has priority over all other logic.
//   - Clears sync flops, count, state (STABLE), sw_db=0, sw_rise=0, sw_busy=0.
//  Synchronizer: s1 <= sw_in; s2 <= s1. The FSM sees only s2.
//  Per-channel FSM (encoding in package):
//   STABLE    if s2 != sw_db[i] -> COUNTING, count <= 1; else count held at 0
//   COUNTING  if s2 == sw_db[i] -> STABLE, count <= 0 (glitch rejected, sw_db unchanged)
//             elif count == DEBOUNCE_CYCLES-1 -> sw_db[i] <= s2, STABLE, count <= 0
//             else count <= count+1
//  Latency: a clean level step first sampled at edge 0 appears on sw_db after edge DEBOUNCE_CYCLES+1.
//  Glitch rule: sw_in pulse held W clock samples.
//   - W >= DEBOUNCE_CYCLES: accepted.
//   - W <= DEBOUNCE_CYCLES-1: rejected, no sw_db change.
//  Bounce in COUNTING restarts the qualification: return to STABLE, re-enter from count 1.
//  Counter never wraps; the terminal compare is exact.
//  sw_busy[i] = (state == COUNTING), decoded from registered state.
//  Simultaneous changes on several channels are handled independently, same latency each.
//  Reset mid-count: the partial count is discarded.
//   - An input held high across reset yields sw_db=1 DEBOUNCE_CYCLES+1 cycles after rst deasserts.
//   - With SW_EDGE_PULSE_EN, a sw_rise pulse also fires then.
// CONFIGURATION
//  SW_EDGE_PULSE_EN defined:
//   - sw_rise[i] is registered; high for exactly the cycle in which sw_db[i] first reads 1.
//   - Low otherwise; no pulse on 1->0.
//  SW_EDGE_PULSE_EN undefined:
//   - sw_rise tied to 4'b0000; edge registers not built.
//   - Port list unchanged.
// STRUCTURE
//  Package sw_debounce_pkg:
//   - typedef db_state_t {STABLE=1'b0, COUNTING=1'b1}
//   - localparam NUM_CH=4
//  Sub-module debounce_channel:
//   - One synchronizer + FSM + counter + optional edge reg.
//   - Instantiated NUM_CH times via generate.
//  Top is wiring only.
// TESTING (bench uses DEBOUNCE_CYCLES=4, CNT_W=4)
//  1 rst=1 for 3 cycles, sw_in=4'hF -> sw_db=0, sw_rise=0, sw_busy=0 throughout reset
//  2 sw_in[0] 0->1 sampled at edge 0, held -> sw_db[0]=1 after edge 5
//    -> sw_rise[0]=1 for that one cycle only (with macro); sw_busy[0]=1 during edges 2..4
//  3 sw_in[1] high for 3 samples then low -> sw_db[1] stays 0, sw_busy[1] returns to 0, no sw_rise
//  4 sw_in[2] high for exactly 4 samples -> sw_db[2]=1 after edge 5, then back to 0 4+1 cycles after the fall
//  5 sw_in=4'hF in one cycle -> all sw_db bits rise on the same cycle; sw_rise=4'hF for one cycle
//  6 sw_in[3] held high, rst pulsed at edge 3 of counting
//    -> sw_db[3] 0 during rst, then 1 exactly 5 cycles after rst release
//  Run 2 and 5 with and without SW_EDGE_PULSE_EN; without the macro sw_rise must be 0 always.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared types and constants for the four-channel switch debouncer.
package sw_debounce_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } db_state_t;

    localparam int NUM_CH = 4;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchronizer, counter-qualified debounce FSM, optional rise pulse.
// Optional feature macro: SW_EDGE_PULSE_EN (registered one-cycle pulse on each accepted 0->1).
module debounce_channel
    import sw_debounce_pkg::*;
#(
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic sw_db,
    output logic sw_rise,
    output logic sw_busy
);

    if ((DEBOUNCE_CYCLES < 2) ||
        (longint'(DEBOUNCE_CYCLES) > ((64'sd1 <<< CNT_W) - 64'sd1))) begin : g_param_check
        $error("debounce_channel: DEBOUNCE_CYCLES must lie in 2 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             db_nxt;

    // Synchronizer: the FSM below only ever looks at s2.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sw_in;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STABLE;
            count <= '0;
            sw_db <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            sw_db <= db_nxt;
        end
    end

    // Any sample matching the current level aborts the run, so a new level needs
    // DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        db_nxt    = sw_db;
        unique case (state)
            STABLE: begin
                if (s2 != sw_db) begin
                    state_nxt = COUNTING;
                    count_nxt = CNT_W'(1);
                end else begin
                    count_nxt = '0;
                end
            end
            COUNTING: begin
                if (s2 == sw_db) begin
                    state_nxt = STABLE;
                    count_nxt = '0;
                end else if (count == TERMINAL) begin
                    db_nxt    = s2;
                    state_nxt = STABLE;
                    count_nxt = '0;
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = STABLE;
                count_nxt = '0;
            end
        endcase
    end

    assign sw_busy = (state == COUNTING);

`ifdef SW_EDGE_PULSE_EN
    // Registered alongside sw_db so the pulse lines up with the first cycle it reads 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_rise <= 1'b0;
        end else begin
            sw_rise <= db_nxt & ~sw_db;
        end
    end
`else
    assign sw_rise = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce_4ch.sv
// Four independent debounced switch inputs feeding the AND stage (sw_db[0..3] -> A, B, C, D).
// Optional feature macro: SW_EDGE_PULSE_EN enables the sw_rise pulses; otherwise sw_rise is 0.
module sw_debounce_4ch
    import sw_debounce_pkg::*;
#(
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] sw_in,
    output logic [NUM_CH-1:0] sw_db,
    output logic [NUM_CH-1:0] sw_rise,
    output logic [NUM_CH-1:0] sw_busy
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .CNT_W           (CNT_W),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .sw_in   (sw_in[i]),
            .sw_db   (sw_db[i]),
            .sw_rise (sw_rise[i]),
            .sw_busy (sw_busy[i])
        );
    end

endmodule

// File: tb/tb_sw_debounce_4ch.sv
// Bench for sw_debounce_4ch: sample-history reference model checked every cycle plus pinned literals.
module tb_sw_debounce_4ch;

    localparam int D     = 4;
    localparam int CNT_W = 4;
`ifdef SW_EDGE_PULSE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw_in = 4'hF;
    logic [3:0] sw_db;
    logic [3:0] sw_rise;
    logic [3:0] sw_busy;

    int total  = 0;
    int passed = 0;

    sw_debounce_4ch #(
        .CNT_W           (CNT_W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_in   (sw_in),
        .sw_db   (sw_db),
        .sw_rise (sw_rise),
        .sw_busy (sw_busy)
    );

    always #5 clk = ~clk;

    // Model: a level is accepted once the last D FSM-visible samples all disagree with it.
    bit [3:0] m_s1, m_s2, m_db, m_rise, m_busy;
    bit [3:0] hist[$];
    bit       started = 1'b0;

    always @(posedge clk) begin : model
        bit [3:0] x;
        bit       all_diff;
        started = 1'b1;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_busy = '0;
            hist.delete();
        end else begin
            x    = m_s2;
            m_s2 = m_s1;
            m_s1 = sw_in;
            hist.push_back(x);
            if (hist.size() > D) void'(hist.pop_front());
            m_rise = '0;
            for (int ch = 0; ch < 4; ch++) begin
                all_diff = (hist.size() == D);
                for (int j = 0; j < hist.size(); j++)
                    if (hist[j][ch] == m_db[ch]) all_diff = 1'b0;
                if (all_diff) begin
                    m_db[ch] = x[ch];
                    if (x[ch] && EDGE_EN) m_rise[ch] = 1'b1;
                end
                m_busy[ch] = (x[ch] != m_db[ch]);
            end
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("model_db",   sw_db,   m_db);
            check("model_rise", sw_rise, m_rise);
            check("model_busy", sw_busy, m_busy);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // 1: reset held with all inputs high
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_db",   sw_db,   4'h0);
            check("rst_rise", sw_rise, 4'h0);
            check("rst_busy", sw_busy, 4'h0);
        end
        rst   = 1'b0;
        sw_in = 4'h0;
        tick(8);
        check("idle_db", sw_db, 4'h0);

        // 2: clean step on channel 0
        sw_in[0] = 1'b1;
        tick(2);
        check("t2_busy_e1", sw_busy & 4'h1, 4'h0);
        tick(1);
        check("t2_busy_e2", sw_busy & 4'h1, 4'h1);
        tick(2);
        check("t2_db_e4",   sw_db & 4'h1,   4'h0);
        check("t2_busy_e4", sw_busy & 4'h1, 4'h1);
        tick(1);
        check("t2_db_e5",   sw_db & 4'h1,   4'h1);
        check("t2_rise_e5", sw_rise & 4'h1, EDGE_EN ? 4'h1 : 4'h0);
        check("t2_busy_e5", sw_busy & 4'h1, 4'h0);
        tick(1);
        check("t2_rise_e6", sw_rise & 4'h1, 4'h0);
        check("t2_db_e6",   sw_db & 4'h1,   4'h1);

        // 3: three-sample glitch on channel 1 is rejected
        sw_in[1] = 1'b1;
        tick(3);
        sw_in[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("t3_db",   sw_db & 4'h2,   4'h0);
            check("t3_rise", sw_rise & 4'h2, 4'h0);
        end
        check("t3_busy_end", sw_busy & 4'h2, 4'h0);

        // 4: four-sample pulse on channel 2 is accepted, then released
        sw_in[2] = 1'b1;
        tick(4);
        sw_in[2] = 1'b0;
        tick(2);
        check("t4_db_e5", sw_db & 4'h4, 4'h4);
        tick(3);
        check("t4_db_e8", sw_db & 4'h4, 4'h4);
        tick(1);
        check("t4_db_e9", sw_db & 4'h4, 4'h0);

        // 5: all channels rise together
        sw_in = 4'h0;
        tick(10);
        check("t5_idle", sw_db, 4'h0);
        sw_in = 4'hF;
        tick(5);
        check("t5_db_e4", sw_db, 4'h0);
        tick(1);
        check("t5_db_e5",   sw_db,   4'hF);
        check("t5_rise_e5", sw_rise, EDGE_EN ? 4'hF : 4'h0);
        tick(1);
        check("t5_rise_e6", sw_rise, 4'h0);

        // 6: reset in the middle of a qualification on channel 3
        sw_in = 4'h0;
        tick(10);
        sw_in = 4'h8;
        tick(4);
        check("t6_busy_pre", sw_busy, 4'h8);
        rst = 1'b1;
        tick(1);
        check("t6_db_rst",   sw_db,   4'h0);
        check("t6_busy_rst", sw_busy, 4'h0);
        rst = 1'b0;
        tick(5);
        check("t6_db_r4", sw_db, 4'h0);
        tick(1);
        check("t6_db_r5",   sw_db,   4'h8);
        check("t6_rise_r5", sw_rise, EDGE_EN ? 4'h8 : 4'h0);
        tick(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
